// File: rtl/whack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : whack_pkg
// Purpose  : Shared types and helpers for the whack-a-mole game engine:
//            game state encoding, maximal LFSR tap table, saturating add.
// Revision : 1.0 - initial release
// ============================================================================
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        FEVER = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Fibonacci tap masks; bit k set means x^(k+1) appears in the polynomial.
    function automatic logic [31:0] lfsr_taps(input int n);
        case (n)
            2:       lfsr_taps = 32'h0000_0003;
            4:       lfsr_taps = 32'h0000_000C;
            6:       lfsr_taps = 32'h0000_0030;
            8:       lfsr_taps = 32'h0000_00B8;
            10:      lfsr_taps = 32'h0000_0240;
            12:      lfsr_taps = 32'h0000_0829;
            14:      lfsr_taps = 32'h0000_2015;
            16:      lfsr_taps = 32'h0000_D008;
            18:      lfsr_taps = 32'h0002_0400;
            20:      lfsr_taps = 32'h0009_0000;
            22:      lfsr_taps = 32'h0030_0000;
            24:      lfsr_taps = 32'h00E1_0000;
            26:      lfsr_taps = 32'h0200_0023;
            28:      lfsr_taps = 32'h0900_0000;
            30:      lfsr_taps = 32'h2000_0029;
            32:      lfsr_taps = 32'h8020_0003;
            default: lfsr_taps = 32'h0000_0003;
        endcase
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        sat_add = (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mole_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : mole_lfsr
// Purpose  : Maximal-length Fibonacci LFSR producing the random mole pattern.
//            Exposes both the current state and the value after one step.
// Revision : 1.0 - initial release
// ============================================================================
module mole_lfsr
    import whack_pkg::*;
#(
    parameter int          N_HOLES = 8,
    parameter int unsigned SEED    = 'hA5
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               step,
    input  logic               load,
    output logic [N_HOLES-1:0] state,
    output logic [N_HOLES-1:0] next_state
);

    localparam logic [N_HOLES-1:0] c_RAW_SEED = N_HOLES'(SEED);
    localparam logic [N_HOLES-1:0] c_SEED     = (c_RAW_SEED == '0) ? N_HOLES'(1) : c_RAW_SEED;
    localparam logic [N_HOLES-1:0] c_TAPS     = N_HOLES'(lfsr_taps(N_HOLES));

    logic [N_HOLES-1:0] r_state;
    logic               w_fb;
    logic [N_HOLES-1:0] w_shift;

    assign w_fb    = ^(r_state & c_TAPS);
    assign w_shift = {r_state[N_HOLES-2:0], w_fb};
    // The all-zero lock-up state is unreachable from a nonzero seed; recover anyway.
    assign next_state = (w_shift == '0) ? c_SEED : w_shift;
    assign state      = r_state;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state <= c_SEED;
        end else if (load) begin
            r_state <= c_SEED;
        end else if (step) begin
            r_state <= next_state;
        end
    end

endmodule
`default_nettype wire

// File: rtl/whack_game_core.sv
`default_nettype none
// ============================================================================
// Module   : whack_game_core
// Purpose  : Whack-a-mole game engine: mole pattern, hit judging, score,
//            combo, fever mode and game timer. Define PAUSE_EN to add pause.
// Revision : 1.0 - initial release
// ============================================================================
module whack_game_core
    import whack_pkg::*;
#(
    parameter int          N_HOLES     = 8,
    parameter int          SCORE_W     = 8,
    parameter int          COMBO_W     = 4,
    parameter int          TIMER_W     = 8,
    parameter int          GAME_TICKS  = 45,
    parameter int          FEVER_COMBO = 10,
    parameter int          FEVER_TICKS = 5,
    parameter int          NORMAL_PTS  = 1,
    parameter int          FEVER_PTS   = 3,
    parameter int unsigned LFSR_SEED   = 'hA5
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               start,
    input  logic               tick,
    input  logic [N_HOLES-1:0] keypad,
`ifdef PAUSE_EN
    input  logic               pause,
`endif
    output logic [N_HOLES-1:0] mole,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [TIMER_W-1:0] timer,
    output logic               fever,
    output logic               finish,
    output logic               hit
);

    localparam int FC_W = (FEVER_TICKS < 2) ? 1 : $clog2(FEVER_TICKS + 1);

    localparam logic [N_HOLES-1:0] c_RAW_SEED    = N_HOLES'(LFSR_SEED);
    localparam logic [N_HOLES-1:0] c_SEED        = (c_RAW_SEED == '0) ? N_HOLES'(1) : c_RAW_SEED;
    localparam logic [N_HOLES-1:0] c_UPPER       = {{(N_HOLES/2){1'b1}}, {(N_HOLES/2){1'b0}}};
    localparam logic [N_HOLES-1:0] c_LOWER       = {{(N_HOLES/2){1'b0}}, {(N_HOLES/2){1'b1}}};
    localparam logic [N_HOLES-1:0] c_ONE_N       = N_HOLES'(1);
    localparam logic [TIMER_W-1:0] c_GAME_TICKS  = TIMER_W'(GAME_TICKS);
    localparam logic [TIMER_W-1:0] c_ONE_T       = TIMER_W'(1);
    localparam logic [COMBO_W-1:0] c_FEVER_COMBO = COMBO_W'(FEVER_COMBO);
    localparam logic [FC_W-1:0]    c_FEVER_TICKS = FC_W'(FEVER_TICKS);
    localparam logic [FC_W-1:0]    c_ONE_F       = FC_W'(1);

    state_t             r_state,     w_state_nxt;
    logic [SCORE_W-1:0] r_score,     w_score_nxt;
    logic [COMBO_W-1:0] r_combo,     w_combo_nxt;
    logic [TIMER_W-1:0] r_timer,     w_timer_nxt;
    logic [N_HOLES-1:0] r_mole,      w_mole_nxt;
    logic [FC_W-1:0]    r_fever_cnt, w_fcnt_nxt;
    logic               r_hit,       w_hit_nxt;
    logic [N_HOLES-1:0] r_key_latch, w_latch_nxt;

    logic               w_pause;
    logic               w_judge;
    logic               w_hit;
    logic               w_onehot;
    logic               w_lfsr_step;
    logic [N_HOLES-1:0] w_lfsr_state;
    logic [N_HOLES-1:0] w_lfsr_next;

`ifdef PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_judge     = tick && !start && !w_pause && ((r_state == PLAY) || (r_state == FEVER));
    assign w_hit       = |(r_mole & r_key_latch);
    assign w_onehot    = (keypad != '0) && ((keypad & (keypad - c_ONE_N)) == '0);
    assign w_lfsr_step = w_judge && (r_state == PLAY);

    mole_lfsr #(
        .N_HOLES (N_HOLES),
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .RESET      (RESET),
        .step       (w_lfsr_step),
        .load       (start),
        .state      (w_lfsr_state),
        .next_state (w_lfsr_next)
    );

    // Only a clean single-key press replaces the latch; the judged key is
    // consumed by the tick so it cannot score twice.
    always_comb begin
        w_latch_nxt = r_key_latch;
        if (w_pause || w_judge) begin
            w_latch_nxt = '0;
        end else if (w_onehot) begin
            w_latch_nxt = keypad;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = r_score;
        w_combo_nxt = r_combo;
        w_timer_nxt = r_timer;
        w_mole_nxt  = r_mole;
        w_fcnt_nxt  = r_fever_cnt;
        w_hit_nxt   = 1'b0;

        if (start) begin
            w_state_nxt = PLAY;
            w_score_nxt = '0;
            w_combo_nxt = '0;
            w_timer_nxt = c_GAME_TICKS;
            w_mole_nxt  = c_SEED;
            w_fcnt_nxt  = '0;
        end else if (w_judge) begin
            w_timer_nxt = r_timer - c_ONE_T;
            w_hit_nxt   = w_hit;
            if (r_state == PLAY) begin
                w_mole_nxt = w_lfsr_next;
                if (w_hit) begin
                    w_score_nxt = SCORE_W'(sat_add(32'(r_score), 32'(NORMAL_PTS), SCORE_W));
                    w_combo_nxt = COMBO_W'(sat_add(32'(r_combo), 32'd1, COMBO_W));
                    if (w_combo_nxt == c_FEVER_COMBO) begin
                        w_state_nxt = FEVER;
                        w_fcnt_nxt  = '0;
                        w_mole_nxt  = c_UPPER;
                    end
                end else begin
                    w_combo_nxt = '0;
                end
            end else begin
                if (w_hit) begin
                    w_score_nxt = SCORE_W'(sat_add(32'(r_score), 32'(FEVER_PTS), SCORE_W));
                end
                w_mole_nxt = (r_mole == c_UPPER) ? c_LOWER : c_UPPER;
                w_fcnt_nxt = r_fever_cnt + c_ONE_F;
                if (w_fcnt_nxt == c_FEVER_TICKS) begin
                    w_combo_nxt = '0;
                    w_state_nxt = PLAY;
                end
            end
            // Game over overrides any fever entry or exit on the final tick.
            if (w_timer_nxt == '0) begin
                w_state_nxt = DONE;
                w_mole_nxt  = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_score     <= '0;
            r_combo     <= '0;
            r_timer     <= c_GAME_TICKS;
            r_mole      <= '0;
            r_fever_cnt <= '0;
            r_hit       <= 1'b0;
            r_key_latch <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_score     <= w_score_nxt;
            r_combo     <= w_combo_nxt;
            r_timer     <= w_timer_nxt;
            r_mole      <= w_mole_nxt;
            r_fever_cnt <= w_fcnt_nxt;
            r_hit       <= w_hit_nxt;
            r_key_latch <= w_latch_nxt;
        end
    end

    assign mole   = r_mole;
    assign score  = r_score;
    assign combo  = r_combo;
    assign timer  = r_timer;
    assign fever  = (r_state == FEVER);
    assign finish = (r_state == DONE);
    assign hit    = r_hit;

endmodule
`default_nettype wire
